// File: rtl/vga_pkg.sv
// Shared VGA 640x480 timing constants and the packed 8-bit RGB pixel type.
// Latency: n/a (package only).
// Backpressure: n/a.
package vga_pkg;

   localparam int H_DISPLAY      = 640;
   localparam int V_DISPLAY      = 480;
   localparam int H_MAX          = 799;
   localparam int V_MAX          = 524;
   localparam int SCREEN_W       = 512;
   localparam int SCREEN_H       = 256;
   localparam int WORDS_PER_LINE = 32;

   // Board pixel packing: {R[2:0], G[2:0], B[1:0]}
   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb8_t;

   function automatic rgb8_t rgb8(input logic [7:0] packed_rgb);
      return rgb8_t'(packed_rgb);
   endfunction

   // Per-pixel side-band carried alongside the RAM fetch through the pipeline.
   typedef struct packed {
      logic       hsync;
      logic       vsync;
      logic       visible;
      logic       in_img;
      logic [3:0] idx;
   } side_t;

endpackage

// File: rtl/scanout_delay.sv
// N-stage shift register advancing only on the pixel strobe; carries pixel side-band.
// Latency: N pix_ce strobes from d_i to q_o.
// Backpressure: none; contents hold while pix_ce_i is low, reset loads RESET_VAL.
// Ports: clk_i, reset_i (sync, active-high), pix_ce_i, d_i[W-1:0] in; q_o[W-1:0] out.
module scanout_delay #(
   parameter int             W         = 8,
   parameter int             N         = 2,
   parameter logic [W-1:0]   RESET_VAL = '0
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          pix_ce_i,
   input  logic [W-1:0]  d_i,
   output logic [W-1:0]  q_o
);

   logic [W-1:0] stage_q [N];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < N; i++) begin
            stage_q[i] <= RESET_VAL;
         end
      end else if (pix_ce_i) begin
         stage_q[0] <= d_i;
         for (int i = 1; i < N; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[N-1];

endmodule

// File: rtl/hack_screen_scanout.sv
// Hack screen scanout: maps VGA hcount/vcount to RGB from the 512x256 mono screen RAM.
// Latency: 3 pix_ce strobes from hcount/vcount/syncs to RGB/HSyncOut/VSyncOut.
// Backpressure: none; every stage advances only on pix_ce, outputs hold while it is low.
// Ports: clk, reset (sync, active-high), pix_ce, hcount/vcount[9:0], hsync_in/vsync_in in;
//        mem_addr[12:0]/mem_rd out, mem_data[15:0] in; Red/Green[2:0], Blue[1:0],
//        HSyncOut/VSyncOut out.
module hack_screen_scanout
   import vga_pkg::*;
#(
   parameter int          H_OFF      = 64,
   parameter int          V_OFF      = 112,
   parameter logic [7:0]  FG_RGB     = 8'h00,
   parameter logic [7:0]  BG_RGB     = 8'hFF,
   parameter logic [7:0]  BORDER_RGB = 8'h03
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_ce,
   input  logic [9:0]  hcount,
   input  logic [9:0]  vcount,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic [12:0] mem_addr,
   output logic        mem_rd,
   input  logic [15:0] mem_data,
   output logic [2:0]  Red,
   output logic [2:0]  Green,
   output logic [1:0]  Blue,
   output logic        HSyncOut,
   output logic        VSyncOut
);

   localparam logic [9:0] H_VIS = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS = 10'(V_DISPLAY);
   localparam logic [9:0] H_LO  = 10'(H_OFF);
   localparam logic [9:0] H_HI  = 10'(H_OFF + SCREEN_W);
   localparam logic [9:0] V_LO  = 10'(V_OFF);
   localparam logic [9:0] V_HI  = 10'(V_OFF + SCREEN_H);

   localparam rgb8_t FG     = rgb8(FG_RGB);
   localparam rgb8_t BG     = rgb8(BG_RGB);
   localparam rgb8_t BORDER = rgb8(BORDER_RGB);

   localparam side_t SIDE_RESET = '{hsync: 1'b1, vsync: 1'b1, visible: 1'b0,
                                    in_img: 1'b0, idx: 4'd0};

   // ---------------- S0: geometry and fetch request ----------------
   logic        visible_d;
   logic        in_img_d;
   logic [8:0]  x_d;
   logic [7:0]  y_d;
   logic        fetch_d;
   side_t       side_d;

   always_comb begin
      visible_d = (hcount < H_VIS) && (vcount < V_VIS);
      in_img_d  = (hcount >= H_LO) && (hcount < H_HI) &&
                  (vcount >= V_LO) && (vcount < V_HI);
      x_d       = '0;
      y_d       = '0;
      if (in_img_d) begin
         x_d = 9'(hcount - H_LO);
         y_d = 8'(vcount - V_LO);
      end
      // First pixel of each 16-pixel word triggers the single read for that word.
      fetch_d        = pix_ce && in_img_d && (x_d[3:0] == 4'd0);
      side_d         = SIDE_RESET;
      side_d.hsync   = hsync_in;
      side_d.vsync   = vsync_in;
      side_d.visible = visible_d;
      side_d.in_img  = in_img_d;
      side_d.idx     = x_d[3:0];
   end

   logic [12:0] mem_addr_q;
   logic        mem_rd_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_addr_q <= '0;
         mem_rd_q   <= 1'b0;
      end else begin
         mem_rd_q <= fetch_d;
         if (fetch_d) begin
            // row*WORDS_PER_LINE + col/16 as a bit concatenation
            mem_addr_q <= {y_d, x_d[8:4]};
         end
      end
   end

   assign mem_addr = mem_addr_q;
   assign mem_rd   = mem_rd_q;

   // ---------------- S0 -> S1 side-band ----------------
   side_t side_s1;

   scanout_delay #(
      .W         ($bits(side_t)),
      .N         (2),
      .RESET_VAL (SIDE_RESET)
   ) u_side_delay (
      .clk_i    (clk),
      .reset_i  (reset),
      .pix_ce_i (pix_ce),
      .d_i      (side_d),
      .q_o      (side_s1)
   );

   // ---------------- S2: word register and colour mux ----------------
   // With back-to-back strobes the RAM word only becomes valid as the fetching
   // pixel enters S2, so the word-aligned pixel takes its bit straight from
   // mem_data and the word is captured for the 15 pixels that follow.
   logic [15:0] word_q;
   logic [15:0] pix_word;
   logic        pix_bit;
   rgb8_t       pix_rgb_d;
   rgb8_t       rgb_q;
   logic        hsync_q;
   logic        vsync_q;

   always_comb begin
      pix_word = (side_s1.idx == 4'd0) ? mem_data : word_q;
      pix_bit  = pix_word[side_s1.idx];   // bit 0 is the leftmost pixel
      if (!side_s1.visible) begin
         pix_rgb_d = '0;
      end else if (!side_s1.in_img) begin
         pix_rgb_d = BORDER;
      end else if (pix_bit) begin
         pix_rgb_d = FG;
      end else begin
         pix_rgb_d = BG;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         word_q  <= '0;
         rgb_q   <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
      end else if (pix_ce) begin
         if (side_s1.in_img && (side_s1.idx == 4'd0)) begin
            word_q <= mem_data;
         end
         rgb_q   <= pix_rgb_d;
         hsync_q <= side_s1.hsync;
         vsync_q <= side_s1.vsync;
      end
   end

   assign Red      = rgb_q.r;
   assign Green    = rgb_q.g;
   assign Blue     = rgb_q.b;
   assign HSyncOut = hsync_q;
   assign VSyncOut = vsync_q;

endmodule

// File: tb/tb_hack_screen_scanout.sv
// Self-checking bench for hack_screen_scanout: scoreboarded pixels, fetch addresses,
// read cadence, stall and mid-line reset behaviour.
// Stimulus: selected full lines from a model VGA generator with random pix_ce gaps.
module tb_hack_screen_scanout;

   logic        clk = 1'b0;
   logic        reset;
   logic        pix_ce;
   logic [9:0]  hcount;
   logic [9:0]  vcount;
   logic        hsync_in;
   logic        vsync_in;
   logic [12:0] mem_addr;
   logic        mem_rd;
   logic [15:0] mem_data = '0;
   logic [2:0]  Red;
   logic [2:0]  Green;
   logic [1:0]  Blue;
   logic        HSyncOut;
   logic        VSyncOut;

   always #5 clk = ~clk;

   hack_screen_scanout dut (
      .clk      (clk),
      .reset    (reset),
      .pix_ce   (pix_ce),
      .hcount   (hcount),
      .vcount   (vcount),
      .hsync_in (hsync_in),
      .vsync_in (vsync_in),
      .mem_addr (mem_addr),
      .mem_rd   (mem_rd),
      .mem_data (mem_data),
      .Red      (Red),
      .Green    (Green),
      .Blue     (Blue),
      .HSyncOut (HSyncOut),
      .VSyncOut (VSyncOut)
   );

   // Screen RAM model: 1-clk read latency, data held until the next read.
   logic [15:0] ram [8192];
   always @(posedge clk) begin
      if (mem_rd) mem_data <= ram[mem_addr];
   end

   typedef struct {
      logic [7:0] rgb;
      logic       hs;
      logic       vs;
      logic       chk;
      int         h;
      int         v;
   } exp_t;

   exp_t        sb[$];
   logic [12:0] fq[$];
   int          errors = 0;
   int          checks = 0;
   int          line_reads = 0;
   logic        word_ok = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_rgb(input int h, input int v);
      int          x;
      int          y;
      logic [15:0] w;
      if (h >= 640 || v >= 480) return 8'h00;
      if (h < 64 || h >= 576 || v < 112 || v >= 368) return 8'h03;
      x = h - 64;
      y = v - 112;
      w = ram[y * 32 + x / 16];
      return w[x % 16] ? 8'h00 : 8'hFF;
   endfunction

   // Every read must carry the address the model expects, in order.
   always @(negedge clk) begin
      if (mem_rd) begin
         line_reads++;
         if (fq.size() > 0) check_eq("rd_addr", {19'd0, mem_addr}, {19'd0, fq.pop_front()});
      end
   end

   task automatic prefill_reset();
      exp_t e;
      e.rgb = 8'h00; e.hs = 1'b1; e.vs = 1'b1; e.chk = 1'b1; e.h = -1; e.v = -1;
      sb.delete();
      fq.delete();
      sb.push_back(e);
      sb.push_back(e);
      word_ok = 1'b0;
   endtask

   task automatic compare_out(input exp_t e);
      logic [7:0] rgb;
      rgb = {Red, Green, Blue};
      if (e.chk) check_eq($sformatf("rgb(%0d,%0d)", e.h, e.v), rgb, e.rgb);
      check_eq($sformatf("hsync(%0d,%0d)", e.h, e.v), HSyncOut, e.hs);
      check_eq($sformatf("vsync(%0d,%0d)", e.h, e.v), VSyncOut, e.vs);
      // Directed points with known colours
      if ((e.h == 63 && e.v == 200) || (e.h == 576 && e.v == 200) || (e.h == 300 && e.v == 111))
         check_eq("border", rgb, 8'h03);
      if (e.h == 700 && e.v == 200) check_eq("blank", rgb, 8'h00);
      if (e.h == 64 && e.v == 112) check_eq("bit0_fg", rgb, 8'h00);
      if (e.h >= 65 && e.h <= 79 && e.v == 112) check_eq("bitn_bg", rgb, 8'hFF);
   endtask

   task automatic drive_pix(input int h, input int v);
      logic in_img;
      logic fetch;
      exp_t e;
      hcount   = 10'(h);
      vcount   = 10'(v);
      hsync_in = !(h >= 656 && h < 752);
      vsync_in = !(v >= 513 && v < 515);
      pix_ce   = 1'b1;
      in_img   = (h >= 64 && h < 576 && v >= 112 && v < 368);
      fetch    = in_img && (((h - 64) % 16) == 0);
      if (fetch) begin
         fq.push_back(13'((v - 112) * 32 + (h - 64) / 16));
         word_ok = 1'b1;
      end
      e.rgb = model_rgb(h, v);
      e.hs  = hsync_in;
      e.vs  = vsync_in;
      e.chk = !in_img || word_ok;
      e.h   = h;
      e.v   = v;
      @(posedge clk);
      #1;
      pix_ce = 1'b0;
      sb.push_back(e);
      check_eq($sformatf("rd(%0d,%0d)", h, v), mem_rd, fetch);
      if (sb.size() > 2) compare_out(sb.pop_front());
      repeat ($urandom_range(0, 1)) begin
         @(posedge clk);
         #1;
      end
   endtask

   int lines[11] = '{0, 111, 112, 113, 200, 367, 479, 480, 513, 514, 524};

   initial begin
      logic [7:0] snap_rgb;
      logic       snap_hs;
      logic       snap_vs;
      int         v;

      for (int i = 0; i < 8192; i++) ram[i] = 16'((i * 40503) ^ (i << 7) ^ 16'h5A3C);
      ram[0] = 16'h0001;

      // Reset held with an active strobe on a fetch-aligned pixel.
      reset = 1'b1; pix_ce = 1'b1; hcount = 10'd64; vcount = 10'd112;
      hsync_in = 1'b0; vsync_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check_eq("rst_rgb", {Red, Green, Blue}, 8'h00);
         check_eq("rst_hs", HSyncOut, 1'b1);
         check_eq("rst_vs", VSyncOut, 1'b1);
         check_eq("rst_rd", mem_rd, 1'b0);
         check_eq("rst_addr", mem_addr, 13'd0);
      end
      reset = 1'b0; pix_ce = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
      prefill_reset();

      foreach (lines[li]) begin
         v = lines[li];
         line_reads = 0;
         for (int h = 0; h < 800; h++) begin
            if (v == 113 && h == 264) begin
               // Mid-line reset at x=200; strobe active to show reset wins.
               reset = 1'b1; pix_ce = 1'b1; hcount = 10'd264;
               @(posedge clk);
               #1;
               reset = 1'b0; pix_ce = 1'b0;
               check_eq("mrst_rgb", {Red, Green, Blue}, 8'h00);
               check_eq("mrst_hs", HSyncOut, 1'b1);
               check_eq("mrst_vs", VSyncOut, 1'b1);
               check_eq("mrst_rd", mem_rd, 1'b0);
               prefill_reset();
            end
            drive_pix(h, v);
            if (v == 112 && h == 64) check_eq("addr0", mem_addr, 13'd0);
            if (v == 367 && h == 560) check_eq("addr8191", mem_addr, 13'd8191);
            if (v == 112 && h == 71) begin
               // Stall at x=7 with a fetch-aligned pixel on the bus.
               snap_rgb = {Red, Green, Blue};
               snap_hs  = HSyncOut;
               snap_vs  = VSyncOut;
               hcount   = 10'd80;
               for (int s = 0; s < 5; s++) begin
                  @(posedge clk);
                  #1;
                  check_eq("stall_rgb", {Red, Green, Blue}, snap_rgb);
                  check_eq("stall_hs", HSyncOut, snap_hs);
                  check_eq("stall_vs", VSyncOut, snap_vs);
                  check_eq("stall_rd", mem_rd, 1'b0);
               end
            end
         end
         check_eq($sformatf("reads_line%0d", v), line_reads,
                  (v >= 112 && v < 368) ? 32 : 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
